// File: rtl/pipelined_carry_select_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_select_adder
//
// Pipelined carry-select adder/subtractor. The operands are split into SEGS
// equal segments. On the accept edge every segment's sum is precomputed twice,
// once for carry-in 0 and once for carry-in 1. Each later stage resolves one
// more segment by selecting between its two precomputed sums with the running
// carry. Results leave through a valid/ready handshake. Throughput is one beat
// per cycle and latency is SEGS cycles.
//
// Parameters
//   WIDTH     operand/sum width, a multiple of SEGS
//   SEGS      number of segments and pipeline stages (>= 1)
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   in_valid  operand beat valid
//   in_ready  beat accepted this cycle (the global pipeline enable)
//   a, b      operands
//   cin       carry-in, add mode only
//   sub       1 = compute a - b
//   out_valid result valid
//   out_ready downstream accepts result
//   sum       result
//   cout      carry-out (subtract: 1 = no borrow)
//   ovf       two's-complement signed overflow
// -----------------------------------------------------------------------------
module pipelined_carry_select_adder #(
   parameter int WIDTH = 64,
   parameter int SEGS  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int SEG_W = WIDTH / SEGS;

   if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_param_check
      $error("WIDTH must be a positive multiple of SEGS");
   end

   // The whole pipeline freezes only when a valid result is refused. A bubble
   // at the output never blocks.
   logic en;
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en;

   logic [WIDTH-1:0] b_eff;
   logic             c0;
   assign b_eff = sub ? ~b : b;
   assign c0    = sub | cin;

   // Precompute every segment for both possible carry-ins.
   logic [WIDTH-1:0] cap_s0, cap_s1;
   logic [SEGS-1:0]  cap_c0, cap_c1;
   logic             cap_m0, cap_m1;

   for (genvar i = 0; i < SEGS; i++) begin : g_pair
      assign {cap_c0[i], cap_s0[i*SEG_W +: SEG_W]} =
         {1'b0, a[i*SEG_W +: SEG_W]} + {1'b0, b_eff[i*SEG_W +: SEG_W]};
      assign {cap_c1[i], cap_s1[i*SEG_W +: SEG_W]} =
         {1'b0, a[i*SEG_W +: SEG_W]} + {1'b0, b_eff[i*SEG_W +: SEG_W]}
         + {{SEG_W{1'b0}}, 1'b1};
   end

   // Carry into the MSB for each top-segment choice: the MSB sum bit is
   // a ^ b ^ carry_in, so the carry is recovered by XOR-ing the operands back out.
   assign cap_m0 = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ cap_s0[WIDTH-1];
   assign cap_m1 = a[WIDTH-1] ^ b_eff[WIDTH-1] ^ cap_s1[WIDTH-1];

   // Intermediate stages 0..SEGS-2. Stage j holds segments 0..j resolved, plus
   // the pairs still pending for segments j+1..SEGS-1. The lowest pending pair
   // sits in the lowest bits.
   for (genvar j = 0; j < SEGS - 1; j++) begin : g_stage
      localparam int NP = SEGS - 1 - j;

      logic                   v, v_d;
      logic [(j+1)*SEG_W-1:0] res, res_d;
      logic                   carry, carry_d;
      logic [NP*SEG_W-1:0]    p0, p1, p0_d, p1_d;
      logic [NP-1:0]          q0, q1, q0_d, q1_d;
      logic                   m0, m1, m0_d, m1_d;

      if (j == 0) begin : g_first
         assign v_d     = in_valid;
         assign res_d   = c0 ? cap_s1[SEG_W-1:0] : cap_s0[SEG_W-1:0];
         assign carry_d = c0 ? cap_c1[0] : cap_c0[0];
         assign p0_d    = cap_s0[WIDTH-1:SEG_W];
         assign p1_d    = cap_s1[WIDTH-1:SEG_W];
         assign q0_d    = cap_c0[SEGS-1:1];
         assign q1_d    = cap_c1[SEGS-1:1];
         assign m0_d    = cap_m0;
         assign m1_d    = cap_m1;
      end else begin : g_next
         assign v_d     = g_stage[j-1].v;
         assign res_d   = {g_stage[j-1].carry ? g_stage[j-1].p1[SEG_W-1:0]
                                              : g_stage[j-1].p0[SEG_W-1:0],
                           g_stage[j-1].res};
         assign carry_d = g_stage[j-1].carry ? g_stage[j-1].q1[0]
                                             : g_stage[j-1].q0[0];
         assign p0_d    = g_stage[j-1].p0[(NP+1)*SEG_W-1:SEG_W];
         assign p1_d    = g_stage[j-1].p1[(NP+1)*SEG_W-1:SEG_W];
         assign q0_d    = g_stage[j-1].q0[NP:1];
         assign q1_d    = g_stage[j-1].q1[NP:1];
         assign m0_d    = g_stage[j-1].m0;
         assign m1_d    = g_stage[j-1].m1;
      end

      // NOTE: sequential state uses non-blocking (<=) so every stage samples
      // the previous stage's pre-edge value, which keeps the pipeline ordered.
      // NOTE: the data registers are reset along with the valid bits, so no X
      // can ever reach sum/cout/ovf and reset behaviour stays deterministic.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v     <= 1'b0;
            res   <= '0;
            carry <= 1'b0;
            p0    <= '0;
            p1    <= '0;
            q0    <= '0;
            q1    <= '0;
            m0    <= 1'b0;
            m1    <= 1'b0;
         end else if (en) begin
            v <= v_d;
            // A bubble moves only its valid bit. The data simply holds.
            if (v_d) begin
               res   <= res_d;
               carry <= carry_d;
               p0    <= p0_d;
               p1    <= p1_d;
               q0    <= q0_d;
               q1    <= q1_d;
               m0    <= m0_d;
               m1    <= m1_d;
            end
         end
      end
   end

   // Final stage: resolve the top segment and register the outputs.
   logic             fin_v_d;
   logic [WIDTH-1:0] fin_sum_d;
   logic             fin_cout_d;
   logic             fin_msbc_d;

   if (SEGS == 1) begin : g_fin_direct
      assign fin_v_d    = in_valid;
      assign fin_sum_d  = c0 ? cap_s1 : cap_s0;
      assign fin_cout_d = c0 ? cap_c1[0] : cap_c0[0];
      assign fin_msbc_d = c0 ? cap_m1 : cap_m0;
   end else begin : g_fin_last
      assign fin_v_d    = g_stage[SEGS-2].v;
      assign fin_sum_d  = {g_stage[SEGS-2].carry ? g_stage[SEGS-2].p1
                                                 : g_stage[SEGS-2].p0,
                           g_stage[SEGS-2].res};
      assign fin_cout_d = g_stage[SEGS-2].carry ? g_stage[SEGS-2].q1[0]
                                                : g_stage[SEGS-2].q0[0];
      assign fin_msbc_d = g_stage[SEGS-2].carry ? g_stage[SEGS-2].m1
                                                : g_stage[SEGS-2].m0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (en) begin
         out_valid <= fin_v_d;
         if (fin_v_d) begin
            sum  <= fin_sum_d;
            cout <= fin_cout_d;
            ovf  <= fin_msbc_d ^ fin_cout_d;
         end
      end
   end

endmodule
